// File: rtl/minterm_sweeper.sv
// Purpose : programmable N-input truth table swept over all 2^N input vectors, each held D cycles.
// Latency : start sampled at edge k -> vec_out=0 / func_out=table[0] / busy=1 after edge k; done one cycle after last sample.
// Backpr. : none; start is sampled only in IDLE, abort wins over a coincident sample (that sample is dropped).
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   tt_load, tt_data  truth-table load (IDLE only); bit i is f(vector i)
//   dwell             cycles per vector, latched at start; 0 behaves as 1
//   start, abort      begin sweep (IDLE only) / cancel sweep (RUN only)
//   vec_out           current input vector, MSB is input "A"
//   func_out          table value for vec_out, registered alongside vec_out
//   sample            high on the last dwell cycle of each vector
//   ones_cnt          number of sampled vectors whose function value is 1
//   busy, done        sweep in progress / one-cycle end-of-sweep pulse

module minterm_sweeper #(
    parameter int N_IN    = 4,
    parameter int DWELL_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tt_load,
    input  logic [(1<<N_IN)-1:0]   tt_data,
    input  logic [DWELL_W-1:0]     dwell,
    input  logic                   start,
    input  logic                   abort,
    output logic [N_IN-1:0]        vec_out,
    output logic                   func_out,
    output logic                   sample,
    output logic [N_IN:0]          ones_cnt,
    output logic                   busy,
    output logic                   done
);

    localparam int NVEC = 1 << N_IN;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [NVEC-1:0]     tt_q,     tt_d;
    logic [DWELL_W-1:0]  dwell_q,  dwell_d;
    logic [DWELL_W-1:0]  cnt_q,    cnt_d;
    logic [N_IN-1:0]     vec_q,    vec_d;
    logic                func_q,   func_d;
    logic [N_IN:0]       ones_q,   ones_d;

    // Derived combinational terms
    logic [DWELL_W-1:0]  dwell_eff;
    logic [NVEC-1:0]     tt_sel;
    logic [N_IN-1:0]     vec_inc;
    logic                at_dwell_end;
    logic                at_last_vec;

    // A zero dwell would never let the 1..D counter match, so clamp it to 1.
    assign dwell_eff    = (dwell == '0) ? DWELL_W'(1) : dwell;

    // A load coinciding with start must already be visible for vector 0.
    assign tt_sel       = tt_load ? tt_data : tt_q;

    assign vec_inc      = vec_q + N_IN'(1);
    assign at_dwell_end = (cnt_q == dwell_q);
    assign at_last_vec  = (vec_q == {N_IN{1'b1}});

    //------------------------------------------------------------------
    // Next-state / datapath
    //------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tt_d    = tt_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        func_d  = func_q;
        ones_d  = ones_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tt_load) begin
                    tt_d = tt_data;
                end
                if (start && !abort) begin
                    state_d = ST_RUN;
                    dwell_d = dwell_eff;
                    ones_d  = '0;
                    vec_d   = '0;
                    cnt_d   = DWELL_W'(1);
                    func_d  = tt_sel[0];
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // Abort outranks a coincident sample: ones_cnt keeps its
                    // partial value without this vector's contribution.
                    state_d = ST_IDLE;
                    vec_d   = '0;
                    func_d  = 1'b0;
                    cnt_d   = DWELL_W'(1);
                end else if (at_dwell_end) begin
                    ones_d = ones_q + (N_IN+1)'(func_q);
                    cnt_d  = DWELL_W'(1);
                    if (at_last_vec) begin
                        // Rollover ends the sweep; there is never a second pass.
                        state_d = ST_DONE;
                        vec_d   = '0;
                        func_d  = 1'b0;
                    end else begin
                        vec_d  = vec_inc;
                        func_d = tt_q[vec_inc];
                    end
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // State registers
    //------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tt_q    <= '0;
            dwell_q <= DWELL_W'(1);
            cnt_q   <= DWELL_W'(1);
            vec_q   <= '0;
            func_q  <= 1'b0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            func_q  <= func_d;
            ones_q  <= ones_d;
        end
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign vec_out  = vec_q;
    assign func_out = func_q;
    assign ones_cnt = ones_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign sample   = (state_q == ST_RUN) && at_dwell_end;

endmodule
